// File: rtl/fp16_pkg.sv
// Shared FP16 constants and payload types for the fraction add / normalize stage.
package fp16_pkg;

  localparam int unsigned FP16_EXP_W   = 5;
  localparam int unsigned FP16_MANT_W  = 10;
  localparam int unsigned FP16_BIAS    = 15;
  localparam int unsigned FP16_EXP_MAX = 31;
  localparam int unsigned FRAC_W       = 13;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_MANT_W-1:0] mant;
  } fp16_t;

  typedef logic signed [FRAC_W:0] frac_s_t;

endpackage

// File: rtl/lzc13.sv
// Leading-zero count of a 13-bit vector; returns 13 when the vector is all zero.
module lzc13 (
  input  logic [12:0] vec_i,
  output logic [3:0]  cnt_c_o
);

  // Ascending scan: the highest set bit is the last to overwrite the count.
  always_comb begin
    cnt_c_o = 4'd13;
    for (int i = 0; i < 13; i++) begin
      if (vec_i[i]) cnt_c_o = 4'(12 - i);
    end
  end

endmodule

// File: rtl/fp16_frac_add_norm.sv
// Two-stage valid/ready pipeline: add aligned signed fractions, then normalize,
// round to nearest even and pack an FP16 result.
module fp16_frac_add_norm
  import fp16_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] frac_a,
  input  logic [13:0] frac_b,
  input  logic [4:0]  exp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
);

  localparam int unsigned SUM_W = FRAC_W + 2;
  localparam int unsigned MAG_W = FRAC_W + 1;
  localparam int unsigned EXP_C = 7;

  logic                    s1_valid_q, s1_valid_d;
  logic [SUM_W-1:0]        s1_sum_q, s1_sum_d;
  logic [FP16_EXP_W-1:0]   s1_exp_q, s1_exp_d;
  logic                    s2_valid_q, s2_valid_d;
  fp16_t                   s2_res_q, s2_res_d;

  logic                    advance_c;
  logic                    sign_c;
  logic [MAG_W-1:0]        mag_c;
  logic [3:0]              lz_c;
  logic [FRAC_W-1:0]       norm_c;
  logic [EXP_C-1:0]        exp_n_c, exp_r_c;
  logic                    round_up_c;
  logic [FP16_MANT_W:0]    mant_r_c;
  fp16_t                   res_c;

  assign advance_c = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || advance_c;
  assign out_valid = s2_valid_q;
  assign result    = s2_res_q;

  // Stage 1: sign-extended sum; 15 bits cannot overflow.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_exp_d   = s1_exp_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d = {frac_a[13], frac_a} + {frac_b[13], frac_b};
        s1_exp_d = exp_in;
      end
    end
  end

  // |sum| < 2^14 for legal operands, so the low 14 bits carry the full magnitude.
  assign sign_c = s1_sum_q[SUM_W-1];
  assign mag_c  = sign_c ? (MAG_W'(0) - s1_sum_q[MAG_W-1:0]) : s1_sum_q[MAG_W-1:0];

  lzc13 u_lzc (
    .vec_i   (mag_c[FRAC_W-1:0]),
    .cnt_c_o (lz_c)
  );

  // Stage 2 datapath: normalize, round to nearest even, pack.
  always_comb begin
    if (mag_c[MAG_W-1]) begin
      norm_c  = mag_c[MAG_W-1:1] | {{(FRAC_W-1){1'b0}}, mag_c[0]};
      exp_n_c = {2'b00, s1_exp_q} + 7'd1;
    end else begin
      norm_c  = mag_c[FRAC_W-1:0] << lz_c;
      exp_n_c = {2'b00, s1_exp_q} - {3'b000, lz_c};
    end

    round_up_c = norm_c[1] & (norm_c[0] | norm_c[2]);
    mant_r_c   = {1'b0, norm_c[11:2]} + {{FP16_MANT_W{1'b0}}, round_up_c};
    exp_r_c    = exp_n_c + {6'b0, mant_r_c[FP16_MANT_W]};

    res_c = '{sign: sign_c, exp: exp_r_c[FP16_EXP_W-1:0], mant: mant_r_c[FP16_MANT_W-1:0]};
    // A normalized non-zero magnitude always has its hidden bit set.
    if (!norm_c[FRAC_W-1]) begin
      res_c = '0;
    end else if (exp_n_c[EXP_C-1] || exp_n_c == '0) begin
      res_c = '{sign: sign_c, exp: '0, mant: '0};
    end else if (exp_r_c >= 7'(FP16_EXP_MAX)) begin
      res_c = '{sign: sign_c, exp: '1, mant: '0};
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    if (advance_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_res_d = res_c;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_exp_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_exp_q   <= s1_exp_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
    end
  end

endmodule

// File: tb/tb_fp16_frac_add_norm.sv
// Scoreboard bench for fp16_frac_add_norm: directed cases plus a randomized
// backpressured stream checked against a value-level rounding model.
module tb_fp16_frac_add_norm;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] frac_a;
  logic [13:0] frac_b;
  logic [4:0]  exp_in;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;

  fp16_frac_add_norm dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .frac_a    (frac_a),
    .frac_b    (frac_b),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 CLK = ~CLK;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  bit          rand_ready = 1'b0;
  bit          ready_val  = 1'b1;
  bit          stall_pend = 1'b0;
  logic [15:0] stall_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  // Value-level model: locate the MSB, round |a+b| to 11 significant bits (RNE).
  function automatic logic [15:0] ref_fp16(input int a, input int b, input int e);
    int s, m, p, ex, q, sh, rem, half;
    bit sg;
    s  = a + b;
    sg = (s < 0);
    m  = sg ? -s : s;
    if (m == 0) return 16'h0000;
    p  = $clog2(m + 1) - 1;
    ex = e + p - 12;
    if (ex <= 0) return {sg, 15'h0000};
    if (p > 10) begin
      sh   = p - 10;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
    end else begin
      q = m << (10 - p);
    end
    if (q == 2048) begin
      q = 1024;
      ex++;
    end
    if (ex >= 31) return {sg, 5'h1F, 10'h000};
    return {sg, 5'(ex), 10'(q)};
  endfunction

  always @(posedge CLK) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // Monitor: pops on every output transfer and checks hold behaviour while stalled.
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST && out_valid) begin
        if (stall_pend) check("stable_result", 32'(result), 32'(stall_val));
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_output: got %h, expected no output", result);
        end else if (out_ready) begin
          check("result", 32'(result), 32'(exp_q.pop_front()));
        end
        stall_pend = !out_ready;
        stall_val  = result;
      end else begin
        if (stall_pend && nRST) check("valid_held", 32'(out_valid), 32'd1);
        stall_pend = 1'b0;
      end
    end
  end

  task automatic send(input logic [13:0] a, input logic [13:0] b, input logic [4:0] e,
                      input logic [15:0] expv, input bit hold);
    bit done;
    done = 1'b0;
    @(negedge CLK);
    in_valid = 1'b1;
    frac_a   = a;
    frac_b   = b;
    exp_in   = e;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (in_ready) begin
        @(posedge CLK);
        exp_q.push_back(expv);
        done = 1'b1;
      end else begin
        @(negedge CLK);
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL accept_timeout: got in_ready=0, expected accept within 200 cycles");
    end
    if (!hold) begin
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(negedge CLK);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic send_rand(input bit hold);
    int a, b, e;
    a = int'($urandom_range(0, 16382)) - 8191;
    b = int'($urandom_range(0, 16382)) - 8191;
    e = int'($urandom_range(1, 30));
    send(14'(a), 14'(b), 5'(e), ref_fp16(a, b, e), hold);
  endtask

  initial begin
    nRST     = 1'b0;
    in_valid = 1'b0;
    frac_a   = '0;
    frac_b   = '0;
    exp_in   = '0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'h0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // 1.0 + 1.0 with latency probe
    send(14'h1000, 14'h1000, 5'd15, 16'h4000, 1'b0);
    @(negedge CLK);
    check("latency_cycle1", 32'(out_valid), 32'd0);
    @(negedge CLK);
    check("latency_cycle2", 32'(out_valid), 32'd1);
    drain();

    send(14'h1000, 14'h3000, 5'd15, 16'h0000, 1'b0);
    send(14'h1000, 14'h3800, 5'd15, 16'h3800, 1'b0);
    send(14'h1000, 14'h0006, 5'd15, 16'h3C02, 1'b0);
    send(14'h1000, 14'h0002, 5'd15, 16'h3C00, 1'b0);
    send(14'h1FFC, 14'h1FFC, 5'd30, 16'h7C00, 1'b0);
    send(14'h1000, 14'h3004, 5'd1,  16'h0000, 1'b0);
    send(14'h2004, 14'h2004, 5'd30, 16'hFC00, 1'b0);
    send(14'h1000, 14'h0FFE, 5'd15, 16'h4000, 1'b0);
    drain();

    // Random stream, in_valid held high, random out_ready
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_rand(i != 7);
    drain();
    for (int i = 0; i < 40; i++) send_rand(i != 39);
    drain();
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    @(posedge CLK);

    // Fill both stages under a stall, then reset mid-cycle
    ready_val = 1'b0;
    @(posedge CLK);
    #2;
    send(14'h1000, 14'h1000, 5'd15, 16'h4000, 1'b1);
    send(14'h1000, 14'h0800, 5'd15, 16'h3E00, 1'b0);
    @(negedge CLK);
    in_valid = 1'b1;
    frac_a   = 14'h1000;
    frac_b   = 14'h0000;
    exp_in   = 5'd15;
    #1;
    check("in_ready_full", 32'(in_ready), 32'd0);
    #2;
    nRST = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result",    32'(result),    32'h0);
    check("rst_mid_in_ready",  32'(in_ready),  32'd1);
    exp_q.delete();
    in_valid  = 1'b0;
    ready_val = 1'b1;
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    send(14'h1000, 14'h1000, 5'd15, 16'h4000, 1'b0);
    drain();

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
